// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small write FIFO; frames leave back-to-back while data is queued.
// Frame shape (data width, parity, stop bits, baud divisor) is set by parameters.
module uart_tx_fifo #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 ovf,
  output logic                 busy,
  output logic                 tx
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state_q, state_n;
  logic [DIV_W-1:0]     div_q, div_n;
  logic [BIT_W-1:0]     bit_q, bit_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 par_q, par_n;
  logic                 tx_n;
  logic                 pop, push, bit_end, head_par;
  logic [DATA_BITS-1:0] head;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count_q, count_n;

  assign push     = wr_en && !full;
  assign head     = mem[rd_ptr];
  assign head_par = (PARITY == 2) ? ^head : ~^head;
  assign bit_end  = (div_q == DIV_W'(CLK_DIV - 1));

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_n = state_q;
    div_n   = div_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    par_n   = par_q;
    tx_n    = tx;
    pop     = 1'b0;
    if (state_q != IDLE) div_n = bit_end ? '0 : div_q + DIV_W'(1);
    case (state_q)
      IDLE: begin
        tx_n  = 1'b1;
        div_n = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: if (bit_end) begin
        state_n = DATA;
        bit_n   = '0;
        tx_n    = shift_q[0];
        shift_n = shift_q >> 1;
      end
      DATA: if (bit_end) begin
        if (bit_q == BIT_W'(DATA_BITS - 1)) begin
          bit_n = '0;
          if (PARITY != 0) begin
            state_n = PAR;
            tx_n    = par_q;
          end else begin
            state_n = STOP;
            tx_n    = 1'b1;
          end
        end else begin
          bit_n   = bit_q + BIT_W'(1);
          tx_n    = shift_q[0];
          shift_n = shift_q >> 1;
        end
      end
      PAR: if (bit_end) begin
        state_n = STOP;
        bit_n   = '0;
        tx_n    = 1'b1;
      end
      STOP: if (bit_end) begin
        if (bit_q == BIT_W'(STOP_BITS - 1)) begin
          bit_n = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          bit_n = bit_q + BIT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
    // Parity is latched from the popped word so later writes cannot disturb the frame.
    if (pop) begin
      shift_n = head;
      par_n   = head_par;
    end
  end

  always_comb begin
    count_n = count_q;
    case ({push, pop})
      2'b10:   count_n = count_q + CNT_W'(1);
      2'b01:   count_n = count_q - CNT_W'(1);
      default: count_n = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_n;
      div_q   <= div_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      par_q   <= par_n;
      tx      <= tx_n;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_n;
      full    <= (count_n == CNT_W'(FIFO_DEPTH));
      ovf     <= wr_en && full;
      busy    <= (state_n != IDLE) || (count_n != '0);
    end
  end

  // Storage has no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLK_DIV=4 across four frame configurations.
module tb_uart_tx_fifo;

  logic clk, rst;
  logic       wr_en_a, full_a, ovf_a, busy_a, tx_a;
  logic [7:0] wr_data_a;
  logic       wr_en_e, full_e, ovf_e, busy_e, tx_e;
  logic [7:0] wr_data_e;
  logic       wr_en_o, full_o, ovf_o, busy_o, tx_o;
  logic [7:0] wr_data_o;
  logic       wr_en_s, full_s, ovf_s, busy_s, tx_s;
  logic [6:0] wr_data_s;

  int errors = 0;
  int checks = 0;

  uart_tx_fifo #(.CLK_DIV(4)) u_a (
    .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_data(wr_data_a),
    .full(full_a), .ovf(ovf_a), .busy(busy_a), .tx(tx_a));
  uart_tx_fifo #(.CLK_DIV(4), .PARITY(2)) u_e (
    .clk(clk), .rst(rst), .wr_en(wr_en_e), .wr_data(wr_data_e),
    .full(full_e), .ovf(ovf_e), .busy(busy_e), .tx(tx_e));
  uart_tx_fifo #(.CLK_DIV(4), .PARITY(1)) u_o (
    .clk(clk), .rst(rst), .wr_en(wr_en_o), .wr_data(wr_data_o),
    .full(full_o), .ovf(ovf_o), .busy(busy_o), .tx(tx_o));
  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(7), .STOP_BITS(2)) u_s (
    .clk(clk), .rst(rst), .wr_en(wr_en_s), .wr_data(wr_data_s),
    .full(full_s), .ovf(ovf_s), .busy(busy_s), .tx(tx_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level for bit slot idx of a frame (0 = start bit).
  function automatic logic exp_bit(input logic [8:0] d, input int nb, input int par, input int idx);
    int ones;
    if (idx == 0) return 1'b0;
    if (idx <= nb) return d[idx-1];
    if (par != 0 && idx == nb + 1) begin
      ones = 0;
      for (int i = 0; i < nb; i++) ones += int'(d[i]);
      return (par == 2) ? logic'(ones % 2 == 1) : logic'(ones % 2 == 0);
    end
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    if (tx_a !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx_a); end
    checks++;
    if (full_a !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full_a); end
    checks++;
    if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf_a); end
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    checks++;
    if (tx_s !== 1'b1) begin errors++; $display("FAIL reset_tx_s got=%b exp=1", tx_s); end
    checks++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_frame();
    logic e;
    wr_en_a = 1'b1; wr_data_a = 8'hA5;
    @(negedge clk);
    wr_en_a = 1'b0;
    if (tx_a !== 1'b1) begin errors++; $display("FAIL basic_pre_tx got=%b exp=1", tx_a); end
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy_a); end
    checks++;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      e = exp_bit(9'h0A5, 8, 0, c / 4);
      if (tx_a !== e) begin errors++; $display("FAIL basic_tx c=%0d got=%b exp=%b", c, tx_a, e); end
      checks++;
    end
    @(negedge clk);
    if (busy_a !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got=%b exp=0", busy_a); end
    checks++;
    if (tx_a !== 1'b1) begin errors++; $display("FAIL basic_idle_tx got=%b exp=1", tx_a); end
    checks++;
  endtask

  task automatic test_parity();
    logic ee, eo;
    wr_en_e = 1'b1; wr_data_e = 8'h07;
    wr_en_o = 1'b1; wr_data_o = 8'h07;
    @(negedge clk);
    wr_en_e = 1'b0; wr_en_o = 1'b0;
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      ee = exp_bit(9'h007, 8, 2, c / 4);
      eo = exp_bit(9'h007, 8, 1, c / 4);
      if (tx_e !== ee) begin errors++; $display("FAIL even_tx c=%0d got=%b exp=%b", c, tx_e, ee); end
      checks++;
      if (tx_o !== eo) begin errors++; $display("FAIL odd_tx c=%0d got=%b exp=%b", c, tx_o, eo); end
      checks++;
    end
    @(negedge clk);
    if (busy_e !== 1'b0) begin errors++; $display("FAIL even_busy_end got=%b exp=0", busy_e); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL odd_busy_end got=%b exp=0", busy_o); end
    checks++;
  endtask

  task automatic test_stop2();
    logic e;
    wr_en_s = 1'b1; wr_data_s = 7'h41;
    @(negedge clk);
    wr_en_s = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      e = exp_bit(9'h041, 7, 0, c / 4);
      if (tx_s !== e) begin errors++; $display("FAIL stop2_tx c=%0d got=%b exp=%b", c, tx_s, e); end
      checks++;
    end
    @(negedge clk);
    if (busy_s !== 1'b0) begin errors++; $display("FAIL stop2_busy_end got=%b exp=0", busy_s); end
    checks++;
  endtask

  task automatic test_fifo_full();
    logic [7:0] bytes [0:5];
    logic e;
    int idx;
    bytes = '{8'h01, 8'h80, 8'hFF, 8'h55, 8'hC3, 8'hAA};
    for (int k = 0; k < 206; k++) begin
      if (k >= 1) begin
        if (k >= 2 && k < 202) begin
          idx = k - 2;
          e = exp_bit({1'b0, bytes[idx / 40]}, 8, 0, (idx % 40) / 4);
        end else e = 1'b1;
        if (tx_a !== e) begin errors++; $display("FAIL fifo_tx k=%0d got=%b exp=%b", k, tx_a, e); end
        checks++;
        if (k <= 45) begin
          e = (k >= 5 && k <= 41);
          if (full_a !== e) begin errors++; $display("FAIL fifo_full k=%0d got=%b exp=%b", k, full_a, e); end
          checks++;
        end
        if (k <= 8) begin
          e = (k == 6);
          if (ovf_a !== e) begin errors++; $display("FAIL fifo_ovf k=%0d got=%b exp=%b", k, ovf_a, e); end
          checks++;
        end
        e = (k < 202);
        if (busy_a !== e) begin errors++; $display("FAIL fifo_busy k=%0d got=%b exp=%b", k, busy_a, e); end
        checks++;
      end
      if (k <= 5) begin
        wr_en_a = 1'b1; wr_data_a = bytes[k];
      end else wr_en_a = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    for (int k = 0; k < 86; k++) begin
      if (k >= 1) begin
        if (k >= 2 && k <= 41) e = exp_bit(9'h096, 8, 0, (k - 2) / 4);
        else if (k >= 43 && k <= 82) e = exp_bit(9'h04B, 8, 0, (k - 43) / 4);
        else e = 1'b1;
        if (tx_a !== e) begin errors++; $display("FAIL b2b_tx k=%0d got=%b exp=%b", k, tx_a, e); end
        checks++;
        e = (k <= 82);
        if (busy_a !== e) begin errors++; $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, busy_a, e); end
        checks++;
      end
      wr_en_a = (k == 0 || k == 41);
      wr_data_a = (k == 41) ? 8'h4B : 8'h96;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic e;
    for (int k = 0; k < 12; k++) begin
      if (k == 10) begin
        e = exp_bit(9'h03C, 8, 0, (k - 2) / 4);
        if (tx_a !== e) begin errors++; $display("FAIL rstmid_pre_tx got=%b exp=%b", tx_a, e); end
        checks++;
      end
      wr_en_a = (k <= 2);
      wr_data_a = (k == 0) ? 8'h3C : ((k == 1) ? 8'h81 : 8'h7E);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    if (tx_a !== 1'b1) begin errors++; $display("FAIL rstmid_tx got=%b exp=1", tx_a); end
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy_a); end
    checks++;
    if (full_a !== 1'b0) begin errors++; $display("FAIL rstmid_full got=%b exp=0", full_a); end
    checks++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_after k=%0d tx=%b busy=%b exp tx=1 busy=0", k, tx_a, busy_a);
      end
      checks++;
    end
  endtask

  initial begin
    rst = 1'b1;
    wr_en_a = 1'b0; wr_data_a = '0;
    wr_en_e = 1'b0; wr_data_e = '0;
    wr_en_o = 1'b0; wr_data_o = '0;
    wr_en_s = 1'b0; wr_data_s = '0;
    test_reset();
    test_basic_frame();
    test_parity();
    test_stop2();
    test_fifo_full();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
